// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: request-stage states,
// vector width and priority-field extraction for the default word layout.
package intc_pkg;

    localparam int INTC_VEC_W  = 8;
    localparam int INTC_PRI_DW = 4;
    localparam int INTC_DW     = INTC_PRI_DW + INTC_VEC_W;

    typedef enum logic [1:0] {
        INTC_ST_IDLE = 2'd0,
        INTC_ST_REQ  = 2'd1,
        INTC_ST_CLR  = 2'd2,
        INTC_ST_GAP  = 2'd3
    } intc_req_st_e;

    function automatic logic [INTC_PRI_DW-1:0] intc_pri(input logic [INTC_DW-1:0] word);
        return word[INTC_DW-1:INTC_VEC_W];
    endfunction

endpackage

// File: rtl/intc_pri_gt.sv
// Unsigned strict greater-than on priority fields; shared with the selection tree.
module intc_pri_gt #(
    parameter int PRI_DW = 4
) (
    input  logic [PRI_DW-1:0] a_i,
    input  logic [PRI_DW-1:0] b_i,
    output logic              gt_o
);

    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/intc_cpu_req.sv
// Per-CPU interrupt request stage: qualifies the tree winner against the mask,
// presents a registered request, pulses a source clear on ack, then waits a guard gap.
module intc_cpu_req
    import intc_pkg::*;
#(
    parameter int DW      = 12,
    parameter int PRI_DW  = 4,
    parameter int CLR_GAP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         win_i,
    input  logic                  win_vld_i,
    input  logic [PRI_DW-1:0]     imask_i,
    input  logic                  int_ack_i,
    output logic                  int_req_o,
    output logic [PRI_DW-1:0]     int_pri_o,
    output logic [INTC_VEC_W-1:0] int_vec_o,
    output logic                  clr_o,
    output logic [INTC_VEC_W-1:0] clr_vec_o
);

    // Handshake: int_req_o is held high until the cycle the CPU raises int_ack_i;
    // that cycle is the transfer, and the CPU samples int_vec_o in it.

    // Keep the counter at least one bit wide so CLR_GAP = 0 still elaborates.
    localparam int CNT_W = (CLR_GAP > 0) ? $clog2(CLR_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (CLR_GAP > 0) ? CNT_W'(CLR_GAP - 1) : '0;

    intc_req_st_e            state_q, state_d;
    logic [PRI_DW-1:0]       pri_q, pri_d;
    logic [INTC_VEC_W-1:0]   vec_q, vec_d;
    logic [INTC_VEC_W-1:0]   clr_vec_q, clr_vec_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pri_gt;
    logic                    q;

    intc_pri_gt #(.PRI_DW(PRI_DW)) u_pri_gt (
        .a_i  (win_i[DW-1:INTC_VEC_W]),
        .b_i  (imask_i),
        .gt_o (pri_gt)
    );

    assign q = win_vld_i & pri_gt;

    always_comb begin
        state_d   = state_q;
        pri_d     = pri_q;
        vec_d     = vec_q;
        clr_vec_d = clr_vec_q;
        cnt_d     = cnt_q;
        case (state_q)
            INTC_ST_IDLE: begin
                if (q) begin
                    pri_d   = win_i[DW-1:INTC_VEC_W];
                    vec_d   = win_i[INTC_VEC_W-1:0];
                    state_d = INTC_ST_REQ;
                end
            end
            INTC_ST_REQ: begin
                // Ack wins over tracking and withdrawal at the same edge.
                if (int_ack_i) begin
                    clr_vec_d = vec_q;
                    state_d   = INTC_ST_CLR;
                end else if (q) begin
                    pri_d = win_i[DW-1:INTC_VEC_W];
                    vec_d = win_i[INTC_VEC_W-1:0];
                end else begin
                    state_d = INTC_ST_IDLE;
                end
            end
            INTC_ST_CLR: begin
                if (CLR_GAP == 0) begin
                    state_d = INTC_ST_IDLE;
                end else begin
                    cnt_d   = GAP_LOAD;
                    state_d = INTC_ST_GAP;
                end
            end
            INTC_ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = INTC_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = INTC_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INTC_ST_IDLE;
            pri_q     <= '0;
            vec_q     <= '0;
            clr_vec_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            vec_q     <= vec_d;
            clr_vec_q <= clr_vec_d;
            cnt_q     <= cnt_d;
        end
    end

    assign int_req_o = (state_q == INTC_ST_REQ);
    assign clr_o     = (state_q == INTC_ST_CLR);
    assign int_pri_o = pri_q;
    assign int_vec_o = vec_q;
    assign clr_vec_o = clr_vec_q;

endmodule

// File: tb/tb_intc_cpu_req.sv
// Directed bench for intc_cpu_req; a second instance with CLR_GAP = 0 shares the inputs.
module tb_intc_cpu_req;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] win_i = '0;
    logic        win_vld_i = 1'b0;
    logic [3:0]  imask_i = '0;
    logic        int_ack_i = 1'b0;

    logic        int_req_o, clr_o;
    logic [3:0]  int_pri_o;
    logic [7:0]  int_vec_o, clr_vec_o;
    logic        g0_req_o, g0_clr_o;
    logic [3:0]  g0_pri_o;
    logic [7:0]  g0_vec_o, g0_clr_vec_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intc_cpu_req #(.DW(12), .PRI_DW(4), .CLR_GAP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_i     (win_i),
        .win_vld_i (win_vld_i),
        .imask_i   (imask_i),
        .int_ack_i (int_ack_i),
        .int_req_o (int_req_o),
        .int_pri_o (int_pri_o),
        .int_vec_o (int_vec_o),
        .clr_o     (clr_o),
        .clr_vec_o (clr_vec_o)
    );

    intc_cpu_req #(.DW(12), .PRI_DW(4), .CLR_GAP(0)) dut_g0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_i     (win_i),
        .win_vld_i (win_vld_i),
        .imask_i   (imask_i),
        .int_ack_i (int_ack_i),
        .int_req_o (g0_req_o),
        .int_pri_o (g0_pri_o),
        .int_vec_o (g0_vec_o),
        .clr_o     (g0_clr_o),
        .clr_vec_o (g0_clr_vec_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        win_vld_i = 1'b0;
        int_ack_i = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({int_req_o, int_pri_o, int_vec_o, clr_o, clr_vec_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_idle: got req=%b pri=%0d vec=%h clr=%b cvec=%h, want all 0",
                     int_req_o, int_pri_o, int_vec_o, clr_o, clr_vec_o);
        end
        win_i = {4'd5, 8'h40}; win_vld_i = 1'b1; imask_i = 4'd3;
        step();
        checks++;
        if (int_req_o !== 1'b1) begin
            errors++; $display("FAIL reset_pre_req: req got %b want 1", int_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({int_req_o, int_pri_o, int_vec_o, clr_o, clr_vec_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_async_req: got req=%b pri=%0d vec=%h clr=%b, want all 0",
                     int_req_o, int_pri_o, int_vec_o, clr_o);
        end
        win_vld_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (int_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: req got %b want 0", int_req_o);
        end
    endtask

    task automatic test_basic_handshake();
        do_reset();
        win_i = {4'd5, 8'h40}; win_vld_i = 1'b1; imask_i = 4'd3;
        step();
        checks++;
        if (int_req_o !== 1'b1 || int_pri_o !== 4'd5 || int_vec_o !== 8'h40) begin
            errors++;
            $display("FAIL basic_req: got req=%b pri=%0d vec=%h want 1/5/40", int_req_o, int_pri_o, int_vec_o);
        end
        int_ack_i = 1'b1;
        step();                     // edge k
        int_ack_i = 1'b0;
        checks++;
        if (int_req_o !== 1'b0 || clr_o !== 1'b1 || clr_vec_o !== 8'h40) begin
            errors++;
            $display("FAIL basic_clr: got req=%b clr=%b cvec=%h want 0/1/40", int_req_o, clr_o, clr_vec_o);
        end
        checks++;
        if (g0_clr_o !== 1'b1 || g0_clr_vec_o !== 8'h40) begin
            errors++; $display("FAIL gap0_clr: got clr=%b cvec=%h want 1/40", g0_clr_o, g0_clr_vec_o);
        end
        step();                     // edge k+1
        checks++;
        if (clr_o !== 1'b0 || int_req_o !== 1'b0) begin
            errors++; $display("FAIL basic_clr_end: got clr=%b req=%b want 0/0", clr_o, int_req_o);
        end
        checks++;
        if (g0_req_o !== 1'b0 || g0_clr_o !== 1'b0) begin
            errors++; $display("FAIL gap0_idle: got req=%b clr=%b want 0/0", g0_req_o, g0_clr_o);
        end
        step();                     // edge k+2
        checks++;
        if (int_req_o !== 1'b0) begin
            errors++; $display("FAIL basic_gap_k2: req got %b want 0", int_req_o);
        end
        checks++;
        if (g0_req_o !== 1'b1) begin
            errors++; $display("FAIL gap0_rereq: req got %b want 1", g0_req_o);
        end
        step();                     // edge k+3
        checks++;
        if (int_req_o !== 1'b0) begin
            errors++; $display("FAIL basic_gap_k3: req got %b want 0", int_req_o);
        end
        step();                     // edge k+4
        checks++;
        if (int_req_o !== 1'b1 || int_vec_o !== 8'h40) begin
            errors++; $display("FAIL basic_rereq_k4: got req=%b vec=%h want 1/40", int_req_o, int_vec_o);
        end
    endtask

    task automatic test_masking();
        do_reset();
        win_i = {4'd3, 8'h11}; win_vld_i = 1'b1; imask_i = 4'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (int_req_o !== 1'b0) begin
                errors++; $display("FAIL mask_equal cycle %0d: req got %b want 0", i, int_req_o);
            end
        end
        imask_i = 4'd2;
        step();
        checks++;
        if (int_req_o !== 1'b1 || int_pri_o !== 4'd3 || int_vec_o !== 8'h11) begin
            errors++;
            $display("FAIL mask_lowered: got req=%b pri=%0d vec=%h want 1/3/11", int_req_o, int_pri_o, int_vec_o);
        end
        do_reset();
        win_i = {4'd0, 8'h22}; win_vld_i = 1'b1; imask_i = 4'd0;
        step();
        checks++;
        if (int_req_o !== 1'b0) begin
            errors++; $display("FAIL mask_pri0: req got %b want 0", int_req_o);
        end
    endtask

    task automatic test_preemption();
        do_reset();
        win_i = {4'd5, 8'h40}; win_vld_i = 1'b1; imask_i = 4'd3;
        step();
        win_i = {4'd9, 8'h24};
        step();
        checks++;
        if (int_req_o !== 1'b1 || int_pri_o !== 4'd9 || int_vec_o !== 8'h24 || clr_o !== 1'b0) begin
            errors++;
            $display("FAIL preempt: got req=%b pri=%0d vec=%h clr=%b want 1/9/24/0",
                     int_req_o, int_pri_o, int_vec_o, clr_o);
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        win_i = {4'd5, 8'h40}; win_vld_i = 1'b1; imask_i = 4'd3;
        step();
        imask_i = 4'd7;
        step();
        checks++;
        if (int_req_o !== 1'b0 || clr_o !== 1'b0 || int_pri_o !== 4'd5 || int_vec_o !== 8'h40) begin
            errors++;
            $display("FAIL withdraw_mask: got req=%b clr=%b pri=%0d vec=%h want 0/0/5/40",
                     int_req_o, clr_o, int_pri_o, int_vec_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (clr_o !== 1'b0) begin
                errors++; $display("FAIL withdraw_noclr cycle %0d: clr got %b want 0", i, clr_o);
            end
        end
        imask_i = 4'd3;
        step();
        win_vld_i = 1'b0;
        step();
        checks++;
        if (int_req_o !== 1'b0 || clr_o !== 1'b0) begin
            errors++; $display("FAIL withdraw_vld: got req=%b clr=%b want 0/0", int_req_o, clr_o);
        end
    endtask

    task automatic test_ack_withdraw();
        do_reset();
        win_i = {4'd6, 8'h5a}; win_vld_i = 1'b1; imask_i = 4'd1;
        step();
        int_ack_i = 1'b1; win_vld_i = 1'b0;
        step();
        int_ack_i = 1'b0;
        checks++;
        if (clr_o !== 1'b1 || clr_vec_o !== 8'h5a || int_req_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_withdraw: got clr=%b cvec=%h req=%b want 1/5a/0", clr_o, clr_vec_o, int_req_o);
        end
    endtask

    task automatic test_ack_ignored();
        do_reset();
        int_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clr_o !== 1'b0 || int_req_o !== 1'b0) begin
                errors++; $display("FAIL ack_idle cycle %0d: got clr=%b req=%b want 0/0", i, clr_o, int_req_o);
            end
        end
        int_ack_i = 1'b0;
    endtask

    task automatic test_reset_during_clr();
        do_reset();
        win_i = {4'd5, 8'h40}; win_vld_i = 1'b1; imask_i = 4'd3;
        step();
        int_ack_i = 1'b1;
        step();
        int_ack_i = 1'b0;
        checks++;
        if (clr_o !== 1'b1) begin
            errors++; $display("FAIL rst_clr_pre: clr got %b want 1", clr_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (clr_o !== 1'b0 || clr_vec_o !== 8'h00 || int_vec_o !== 8'h00) begin
            errors++;
            $display("FAIL rst_clr_async: got clr=%b cvec=%h vec=%h want 0/00/00", clr_o, clr_vec_o, int_vec_o);
        end
        win_vld_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_handshake();
        test_masking();
        test_preemption();
        test_withdrawal();
        test_ack_withdraw();
        test_ack_ignored();
        test_reset_during_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
